// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among NUM_CORES cores.
// Define MEM_ARB_LOCK_EN to honour core_lock (exclusive ownership via a LOCKED state).
module mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_wr,
    input  logic [NUM_CORES-1:0]        core_lock,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_gnt,
    output logic [NUM_CORES-1:0]        core_rvalid,
    output logic [DATA_W-1:0]           core_rdata,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_data_in,
    output logic                        mem_write,
    output logic                        mem_read,
    input  logic [DATA_W-1:0]           mem_data_out
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic [PTR_W-1:0] sel_idx;
    logic [PTR_W-1:0] cand;
    logic             sel_valid;
    logic             sel_wr;
    int               rr_idx;

`ifdef MEM_ARB_LOCK_EN
    typedef enum logic {UNLOCKED, LOCKED} state_t;

    state_t           state;
    state_t           state_next;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] owner_next;
    logic             sel_lock;
`else
    logic             unused_lock;
    assign unused_lock = ^core_lock;
`endif

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] k);
        if (int'(k) == NUM_CORES - 1) begin
            return '0;
        end
        return k + 1'b1;
    endfunction

    // Pick the first requester at or after ptr; a lock owner overrides the search.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        rr_idx    = 0;
        for (int off = 0; off < NUM_CORES; off++) begin
            rr_idx = (int'(ptr) + off) % NUM_CORES;
            cand   = PTR_W'(rr_idx);
            if (!sel_valid && core_req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
`ifdef MEM_ARB_LOCK_EN
        if (state == LOCKED) begin
            sel_valid = core_req[owner];
            sel_idx   = owner;
        end
`endif
        if (reset) begin
            sel_valid = 1'b0;
        end
    end

    always_comb begin
        core_gnt    = '0;
        mem_address = '0;
        mem_data_in = '0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        sel_wr      = core_wr[sel_idx];
        if (sel_valid) begin
            core_gnt[sel_idx] = 1'b1;
            mem_address       = core_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
            mem_data_in       = core_wdata[int'(sel_idx)*DATA_W +: DATA_W];
            mem_write         = sel_wr;
            mem_read          = ~sel_wr;
        end
    end

    always_comb begin
        ptr_next = ptr;
`ifdef MEM_ARB_LOCK_EN
        state_next = state;
        owner_next = owner;
        sel_lock   = core_lock[sel_idx];
        if (sel_valid) begin
            case (state)
                UNLOCKED: begin
                    if (sel_lock) begin
                        state_next = LOCKED;
                        owner_next = sel_idx;
                    end else begin
                        ptr_next = wrap_inc(sel_idx);
                    end
                end
                LOCKED: begin
                    if (!sel_lock) begin
                        state_next = UNLOCKED;
                        ptr_next   = wrap_inc(owner);
                    end
                end
                default: state_next = UNLOCKED;
            endcase
        end
`else
        if (sel_valid) begin
            ptr_next = wrap_inc(sel_idx);
        end
`endif
    end

`ifdef MEM_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= UNLOCKED;
            owner <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end
`endif

    // Read data is captured on the accept edge so it is seen by the core one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            core_rvalid <= '0;
            core_rdata  <= '0;
        end else begin
            ptr         <= ptr_next;
            core_rvalid <= '0;
            if (sel_valid && !sel_wr) begin
                core_rvalid[sel_idx] <= 1'b1;
                core_rdata           <= mem_data_out;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a read-return scoreboard.
// Expectations for the lock scenario follow MEM_ARB_LOCK_EN.
module tb_mem_arbiter;

    localparam int NC = 4;

    logic          clk;
    logic          reset;
    logic [NC-1:0] core_req;
    logic [NC-1:0] core_wr;
    logic [NC-1:0] core_lock;
    logic [NC*16-1:0] core_addr;
    logic [NC*16-1:0] core_wdata;
    logic [NC-1:0] core_gnt;
    logic [NC-1:0] core_rvalid;
    logic [15:0]   core_rdata;
    logic [15:0]   mem_address;
    logic [15:0]   mem_data_in;
    logic          mem_write;
    logic          mem_read;
    logic [15:0]   mem_data_out;

    logic [15:0] mem [0:65535];

    typedef struct {
        logic [NC-1:0] vld;
        logic [15:0]   data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 1'b0;
    int   gnt_cnt [NC];

    mem_arbiter #(.NUM_CORES(NC), .ADDR_W(16), .DATA_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_wr      (core_wr),
        .core_lock    (core_lock),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_gnt     (core_gnt),
        .core_rvalid  (core_rvalid),
        .core_rdata   (core_rdata),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write committed on the rising edge.
    assign mem_data_out = mem[mem_address];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_data_in;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [NC-1:0] req);
        @(negedge clk);
        reset    = rst;
        core_req = req;
    endtask

    task automatic setCore(input int i, input logic wr, input logic lock,
                           input logic [15:0] addr, input logic [15:0] wdata);
        core_wr[i]              = wr;
        core_lock[i]            = lock;
        core_addr[i*16 +: 16]   = addr;
        core_wdata[i*16 +: 16]  = wdata;
    endtask

    task automatic checkGrant(input string tag, input logic [NC-1:0] exp_gnt, input logic [15:0] exp_rdata);
        exp_t e;
        #1;
        checkOutput(tag, 32'(core_gnt), 32'(exp_gnt));
        for (int i = 0; i < NC; i++) begin
            if (exp_gnt[i] && !core_wr[i]) begin
                e.vld  = exp_gnt;
                e.data = exp_rdata;
                sb.push_back(e);
            end
        end
    endtask

    // Scoreboard: each accepted read must return exactly one cycle later.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (chk_en) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("rvalid", 32'(core_rvalid), 32'(e.vld));
                checkOutput("rdata", 32'(core_rdata), 32'(e.data));
            end else begin
                checkOutput("rvalid_idle", 32'(core_rvalid), 32'(0));
            end
        end
    end

    initial begin
        logic [NC-1:0] g;
        reset      = 1'b1;
        core_req   = '0;
        core_wr    = '0;
        core_lock  = '0;
        core_addr  = '0;
        core_wdata = '0;
        mem[5]     = 16'd92;
        for (int i = 0; i < NC; i++) begin
            mem[100 + i] = 16'h1000 + 16'(i);
            gnt_cnt[i]   = 0;
        end

        applyStimulus(1'b1, 4'b0000);
        checkGrant("rst_gnt0", 4'b0000, 16'h0);
        applyStimulus(1'b1, 4'b0000);
        checkGrant("rst_gnt1", 4'b0000, 16'h0);

        applyStimulus(1'b0, 4'b0000);
        checkOutput("rst_rvalid", 32'(core_rvalid), 32'(0));
        checkOutput("rst_rdata", 32'(core_rdata), 32'(0));
        chk_en = 1'b1;
        checkGrant("idle_gnt", 4'b0000, 16'h0);

        // Single read by core 2
        applyStimulus(1'b0, 4'b0100);
        setCore(2, 1'b0, 1'b0, 16'd5, 16'h0);
        checkGrant("rd_gnt", 4'b0100, 16'd92);
        checkOutput("rd_mem_read", 32'(mem_read), 32'(1));
        checkOutput("rd_mem_write", 32'(mem_write), 32'(0));
        checkOutput("rd_mem_addr", 32'(mem_address), 32'(5));
        applyStimulus(1'b0, 4'b0000);
        checkGrant("idle_gnt2", 4'b0000, 16'h0);
        checkOutput("idle_mem_read", 32'(mem_read), 32'(0));
        checkOutput("idle_mem_addr", 32'(mem_address), 32'(0));

        // Write then read back by core 0
        applyStimulus(1'b0, 4'b0001);
        setCore(0, 1'b1, 1'b0, 16'd999, 16'h1234);
        checkGrant("wr_gnt", 4'b0001, 16'h0);
        checkOutput("wr_mem_write", 32'(mem_write), 32'(1));
        checkOutput("wr_mem_data", 32'(mem_data_in), 32'h1234);
        applyStimulus(1'b0, 4'b0001);
        setCore(0, 1'b0, 1'b0, 16'd999, 16'h0);
        checkGrant("rb_gnt", 4'b0001, 16'h1234);
        applyStimulus(1'b0, 4'b0000);
        checkGrant("idle_gnt3", 4'b0000, 16'h0);

        // Fairness from reset: all cores read continuously
        applyStimulus(1'b1, 4'b0000);
        checkGrant("rst2_gnt", 4'b0000, 16'h0);
        for (int n = 0; n < 100; n++) begin
            applyStimulus(1'b0, 4'b1111);
            for (int i = 0; i < NC; i++) setCore(i, 1'b0, 1'b0, 16'(100 + i), 16'h0);
            g = 4'(1 << (n % NC));
            checkGrant("fair_gnt", g, 16'h1000 + 16'(n % NC));
            for (int i = 0; i < NC; i++) if (core_gnt[i]) gnt_cnt[i]++;
        end
        for (int i = 0; i < NC; i++) checkOutput("fair_count", 32'(gnt_cnt[i]), 32'd25);
        applyStimulus(1'b0, 4'b0000);
        checkGrant("idle_gnt4", 4'b0000, 16'h0);

        // Move the pointer to core 1, then core 1 runs lock=1,1,0 against full contention
        applyStimulus(1'b0, 4'b0001);
        setCore(0, 1'b0, 1'b0, 16'd100, 16'h0);
        checkGrant("pre_lock_gnt", 4'b0001, 16'h1000);
        applyStimulus(1'b0, 4'b1111);
        setCore(1, 1'b0, 1'b1, 16'd101, 16'h0);
        checkGrant("lock_a", 4'b0010, 16'h1001);
        applyStimulus(1'b0, 4'b1111);
        setCore(1, 1'b0, 1'b1, 16'd101, 16'h0);
`ifdef MEM_ARB_LOCK_EN
        checkGrant("lock_b", 4'b0010, 16'h1001);
`else
        checkGrant("lock_b", 4'b0100, 16'h1002);
`endif
        applyStimulus(1'b0, 4'b1111);
        setCore(1, 1'b0, 1'b0, 16'd101, 16'h0);
`ifdef MEM_ARB_LOCK_EN
        checkGrant("lock_c", 4'b0010, 16'h1001);
`else
        checkGrant("lock_c", 4'b1000, 16'h1003);
`endif
        applyStimulus(1'b0, 4'b1111);
`ifdef MEM_ARB_LOCK_EN
        checkGrant("lock_d", 4'b0100, 16'h1002);
`else
        checkGrant("lock_d", 4'b0001, 16'h1000);
`endif

        // Core 3 takes the lock, then reset arrives while core 0 waits
        applyStimulus(1'b0, 4'b1000);
        setCore(3, 1'b0, 1'b1, 16'd103, 16'h0);
        checkGrant("lock3_gnt", 4'b1000, 16'h1003);
        applyStimulus(1'b0, 4'b0001);
        setCore(3, 1'b0, 1'b0, 16'd103, 16'h0);
        setCore(0, 1'b1, 1'b0, 16'd77, 16'hBEEF);
`ifdef MEM_ARB_LOCK_EN
        checkGrant("locked_out", 4'b0000, 16'h0);
`else
        checkGrant("locked_out", 4'b0001, 16'h0);
`endif
        applyStimulus(1'b1, 4'b0001);
        checkGrant("rst3_gnt", 4'b0000, 16'h0);
        checkOutput("rst3_mem_write", 32'(mem_write), 32'(0));
        applyStimulus(1'b0, 4'b0001);
        checkOutput("rst3_rdata", 32'(core_rdata), 32'(0));
        checkGrant("post_rst_gnt", 4'b0001, 16'h0);
        applyStimulus(1'b0, 4'b0001);
        setCore(0, 1'b0, 1'b0, 16'd77, 16'h0);
        checkGrant("post_rst_rd", 4'b0001, 16'hBEEF);
        applyStimulus(1'b0, 4'b0000);
        checkGrant("idle_gnt5", 4'b0000, 16'h0);
        applyStimulus(1'b0, 4'b0000);
        checkGrant("idle_gnt6", 4'b0000, 16'h0);
        @(posedge clk);
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
